// File: rtl/vec_mac.sv
// Multi-lane signed vector MAC: streams vec_len operand beats into per-lane
// accumulators, adds a scaled bias, saturates (optional ReLU) and hands off one result.
module vec_mac #(
  parameter int A_BITWIDTH   = 8,
  parameter int B_BITWIDTH   = A_BITWIDTH,
  parameter int LANES        = 4,
  parameter int ACC_BITWIDTH = 28,
  parameter int OUT_BITWIDTH = 20,
  parameter int FRAC_BITS    = 8,
  parameter int LEN_BITWIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            start,
  input  logic [LEN_BITWIDTH-1:0]         vec_len,
  input  logic [LANES*OUT_BITWIDTH-1:0]   bias,
  input  logic                            relu_en,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [LANES*A_BITWIDTH-1:0]     data_a,
  input  logic [LANES*B_BITWIDTH-1:0]     data_b,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [LANES*OUT_BITWIDTH-1:0]   out,
  output logic                            busy
);

  localparam int PROD_W = A_BITWIDTH + B_BITWIDTH;

  localparam logic signed [ACC_BITWIDTH-1:0] SAT_MAX =
    {{(ACC_BITWIDTH-OUT_BITWIDTH+1){1'b0}}, {(OUT_BITWIDTH-1){1'b1}}};
  localparam logic signed [ACC_BITWIDTH-1:0] SAT_MIN =
    {{(ACC_BITWIDTH-OUT_BITWIDTH+1){1'b1}}, {(OUT_BITWIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACCUM = 3'd1,
    BIAS  = 3'd2,
    SAT   = 3'd3,
    OUT   = 3'd4
  } state_t;

  state_t state, state_next;

  logic [LEN_BITWIDTH-1:0]          len_q;
  logic [LEN_BITWIDTH-1:0]          cnt;
  logic [LEN_BITWIDTH-1:0]          cnt_inc;
  logic [LANES*OUT_BITWIDTH-1:0]    bias_q;
  logic                             relu_q;
  logic                             beat;

  logic signed [ACC_BITWIDTH-1:0]   acc      [LANES];
  logic signed [PROD_W-1:0]         prod     [LANES];
  logic signed [ACC_BITWIDTH-1:0]   prod_ext [LANES];
  logic signed [ACC_BITWIDTH-1:0]   bias_ext [LANES];
  logic signed [OUT_BITWIDTH-1:0]   clamp    [LANES];
  logic [LANES*OUT_BITWIDTH-1:0]    sat_res;

  assign beat    = in_valid && (state == ACCUM);
  assign cnt_inc = cnt + 1'b1;

  // Per-lane product, scaled bias and saturated/ReLU'd result, all combinational.
  always_comb begin
    sat_res = '0;
    for (int i = 0; i < LANES; i++) begin
      prod[i]     = $signed(data_a[i*A_BITWIDTH +: A_BITWIDTH]) *
                    $signed(data_b[i*B_BITWIDTH +: B_BITWIDTH]);
      prod_ext[i] = {{(ACC_BITWIDTH-PROD_W){prod[i][PROD_W-1]}}, prod[i]};
      bias_ext[i] = {{(ACC_BITWIDTH-OUT_BITWIDTH){bias_q[i*OUT_BITWIDTH+OUT_BITWIDTH-1]}},
                     bias_q[i*OUT_BITWIDTH +: OUT_BITWIDTH]} <<< FRAC_BITS;
      if (acc[i] > SAT_MAX) begin
        clamp[i] = SAT_MAX[OUT_BITWIDTH-1:0];
      end else if (acc[i] < SAT_MIN) begin
        clamp[i] = SAT_MIN[OUT_BITWIDTH-1:0];
      end else begin
        clamp[i] = acc[i][OUT_BITWIDTH-1:0];
      end
      if (relu_q && clamp[i][OUT_BITWIDTH-1]) begin
        clamp[i] = '0;
      end
      sat_res[i*OUT_BITWIDTH +: OUT_BITWIDTH] = clamp[i];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (vec_len == '0) ? BIAS : ACCUM;
      ACCUM:   if (beat && (cnt_inc == len_q)) state_next = BIAS;
      BIAS:    state_next = SAT;
      SAT:     state_next = OUT;
      OUT:     if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ACCUM);
    busy      = (state != IDLE);
    out_valid = (state == OUT);
  end

  // Job datapath; out is only written in SAT so it holds through OUT and beyond.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      len_q  <= '0;
      cnt    <= '0;
      bias_q <= '0;
      relu_q <= 1'b0;
      out    <= '0;
      for (int i = 0; i < LANES; i++) acc[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len_q  <= vec_len;
            bias_q <= bias;
            relu_q <= relu_en;
            cnt    <= '0;
            for (int i = 0; i < LANES; i++) acc[i] <= '0;
          end
        end
        ACCUM: begin
          if (beat) begin
            cnt <= cnt_inc;
            for (int i = 0; i < LANES; i++) acc[i] <= acc[i] + prod_ext[i];
          end
        end
        BIAS: begin
          for (int i = 0; i < LANES; i++) acc[i] <= acc[i] + bias_ext[i];
        end
        SAT: begin
          out <= sat_res;
        end
        default: ;
      endcase
    end
  end

endmodule
